// File: rtl/busy_count_grant_ctrl_pkg.sv
// Shared types and default constants for the busy-count grant controller.
// The optional watchdog is enabled by defining BUSY_GNT_TIMEOUT_EN.
package busy_gnt_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        WAIT  = 2'd2,
        GRANT = 2'd3
    } gnt_state_e;

    localparam int DEF_BUSY_COUNT = 3;
    localparam int DEF_GNT_GAP    = 0;
    localparam int DEF_TIMEOUT    = 64;

    function automatic logic is_active(input gnt_state_e s);
        return (s == COUNT) || (s == WAIT);
    endfunction

endpackage

// File: rtl/busy_count_grant_ctrl_if.sv
// req/busy/gnt handshake bundle. Handshake: req is a one-cycle request pulse
// (taken in IDLE/GRANT), busy is sampled only while active, gnt answers once.
interface busy_count_grant_ctrl_if #(
    parameter int CNT_W = 7
);
    import busy_gnt_pkg::*;

    logic             req;
    logic             busy;
    logic             gnt;
    logic             active;
    logic [CNT_W-1:0] busy_cnt;
    logic             err_extra;
    logic             err_timeout;
    logic             req_dropped;
    gnt_state_e       state;

    modport master (
        output req, busy,
        input  gnt, active, busy_cnt, err_extra, err_timeout, req_dropped, state
    );

    modport slave (
        input  req, busy,
        output gnt, active, busy_cnt, err_extra, err_timeout, req_dropped, state
    );

endinterface

// File: rtl/busy_count_grant_ctrl_wdog.sv
// Watchdog counter for the grant controller, built only with BUSY_GNT_TIMEOUT_EN.
// expired is high during the TIMEOUT-th enabled cycle after a clear.
module gnt_timeout_wdog #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt_q <= '0;
        end else if (enable && (cnt_q != CNT_W'(TIMEOUT))) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // cnt_q+1 is the number of the cycle being spent in COUNT/WAIT
    assign expired = enable && (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/busy_count_grant_ctrl.sv
// Grant controller: counts BUSY_COUNT busy cycles, waits GNT_GAP quiet cycles,
// then pulses gnt. Optional watchdog under BUSY_GNT_TIMEOUT_EN.
module busy_count_grant_ctrl
    import busy_gnt_pkg::*;
#(
    parameter int BUSY_COUNT = DEF_BUSY_COUNT,
    parameter int GNT_GAP    = DEF_GNT_GAP,
    parameter int TIMEOUT    = DEF_TIMEOUT,
    parameter int CNT_W      = $clog2(TIMEOUT + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    busy_count_grant_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] BC_C  = CNT_W'(BUSY_COUNT);
    localparam logic [CNT_W-1:0] GAP_C = CNT_W'(GNT_GAP);

    gnt_state_e       state_q, state_d;
    logic [CNT_W-1:0] busy_cnt_q, busy_cnt_d;
    logic [CNT_W-1:0] gap_q, gap_d;
    logic             extra_d, timeout_d, dropped_d;
    logic             wdog_expired;

`ifdef BUSY_GNT_TIMEOUT_EN
    logic wdog_clear;
    logic wdog_enable;

    assign wdog_clear  = ((state_q == IDLE) || (state_q == GRANT)) && bus.req;
    assign wdog_enable = is_active(state_q);

    gnt_timeout_wdog #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (wdog_clear),
        .enable  (wdog_enable),
        .expired (wdog_expired)
    );
`else
    assign wdog_expired = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        busy_cnt_d = busy_cnt_q;
        gap_d      = gap_q;
        extra_d    = 1'b0;
        timeout_d  = 1'b0;
        dropped_d  = 1'b0;

        case (state_q)
            IDLE, GRANT: begin
                // busy is ignored here, so a req+busy cycle never counts that busy
                if (bus.req) begin
                    state_d    = COUNT;
                    busy_cnt_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            COUNT: begin
                dropped_d = bus.req;
                if (bus.busy && (busy_cnt_q != BC_C)) begin
                    busy_cnt_d = busy_cnt_q + CNT_W'(1);
                    if (busy_cnt_d == BC_C) begin
                        if (GNT_GAP == 0) begin
                            state_d = GRANT;
                        end else begin
                            state_d = WAIT;
                            gap_d   = '0;
                        end
                    end
                end
            end
            WAIT: begin
                dropped_d = bus.req;
                if (bus.busy) begin
                    extra_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + CNT_W'(1);
                    if (gap_d == GAP_C) begin
                        state_d = GRANT;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Expiry only bites if the request would otherwise stay in flight,
        // so a grant or a busy-in-WAIT error on the same edge takes precedence.
        if (wdog_expired && is_active(state_q) && is_active(state_d)) begin
            timeout_d = 1'b1;
            state_d   = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            busy_cnt_q      <= '0;
            gap_q           <= '0;
            bus.gnt         <= 1'b0;
            bus.active      <= 1'b0;
            bus.err_extra   <= 1'b0;
            bus.err_timeout <= 1'b0;
            bus.req_dropped <= 1'b0;
        end else begin
            state_q         <= state_d;
            busy_cnt_q      <= busy_cnt_d;
            gap_q           <= gap_d;
            bus.gnt         <= (state_d == GRANT);
            bus.active      <= is_active(state_d);
            bus.err_extra   <= extra_d;
            bus.err_timeout <= timeout_d;
            bus.req_dropped <= dropped_d;
        end
    end

    assign bus.busy_cnt = busy_cnt_q;
    assign bus.state    = state_q;

endmodule

// File: tb/tb_busy_count_grant_ctrl.sv
// Bench for busy_count_grant_ctrl: two instances (GNT_GAP 0 and 5) share stimulus
// and are compared every cycle against a transaction-level reference model.
module tb_busy_count_grant_ctrl;
  import busy_gnt_pkg::*;

  localparam int BC   = 3;
  localparam int TO   = 20;
  localparam int CW   = 5;
  localparam int GAP0 = 0;
  localparam int GAP1 = 5;
`ifdef BUSY_GNT_TIMEOUT_EN
  localparam bit TO_ON = 1'b1;
`else
  localparam bit TO_ON = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_d = 1'b0;
  logic busy_d = 1'b0;
  always #5 clk = ~clk;

  busy_count_grant_ctrl_if #(.CNT_W(CW)) if0 ();
  busy_count_grant_ctrl_if #(.CNT_W(CW)) if1 ();
  assign if0.req  = req_d;
  assign if0.busy = busy_d;
  assign if1.req  = req_d;
  assign if1.busy = busy_d;

  busy_count_grant_ctrl #(.BUSY_COUNT(BC), .GNT_GAP(GAP0), .TIMEOUT(TO), .CNT_W(CW)) u0 (
    .clk (clk),
    .rst (rst),
    .bus (if0)
  );
  busy_count_grant_ctrl #(.BUSY_COUNT(BC), .GNT_GAP(GAP1), .TIMEOUT(TO), .CNT_W(CW)) u1 (
    .clk (clk),
    .rst (rst),
    .bus (if1)
  );

  int n_cmp = 0;
  int n_err = 0;

  // reference model: one outstanding request per instance
  bit m_fly[2];
  bit m_quiet[2];
  int m_nb[2];
  int m_nq[2];
  int m_age[2];
  bit e_gnt[2], e_act[2], e_ext[2], e_to[2], e_drop[2];
  int e_cnt[2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input int i, input int gap, input bit r, input bit b, input bit rs);
    e_ext[i]  = 1'b0;
    e_to[i]   = 1'b0;
    e_drop[i] = 1'b0;
    e_gnt[i]  = 1'b0;
    if (rs) begin
      m_fly[i] = 1'b0; m_quiet[i] = 1'b0;
      m_nb[i] = 0; m_nq[i] = 0; m_age[i] = 0;
    end else if (!m_fly[i]) begin
      if (r) begin
        m_fly[i] = 1'b1; m_quiet[i] = 1'b0;
        m_nb[i] = 0; m_nq[i] = 0; m_age[i] = 0;
      end
    end else begin
      e_drop[i] = r;
      m_age[i]++;
      if (!m_quiet[i]) begin
        if (b) begin
          m_nb[i]++;
          if (m_nb[i] == BC) begin
            if (gap == 0) begin
              e_gnt[i] = 1'b1;
              m_fly[i] = 1'b0;
            end else begin
              m_quiet[i] = 1'b1;
              m_nq[i] = 0;
            end
          end
        end
      end else if (b) begin
        e_ext[i] = 1'b1;
        m_fly[i] = 1'b0;
      end else begin
        m_nq[i]++;
        if (m_nq[i] == gap) begin
          e_gnt[i] = 1'b1;
          m_fly[i] = 1'b0;
        end
      end
      if (TO_ON && m_fly[i] && (m_age[i] == TO)) begin
        e_to[i]  = 1'b1;
        m_fly[i] = 1'b0;
      end
    end
    e_act[i] = m_fly[i];
    e_cnt[i] = m_nb[i];
  endtask

  task automatic compare_all();
    check_eq("gnt0", 32'(if0.gnt), 32'(e_gnt[0]));
    check_eq("active0", 32'(if0.active), 32'(e_act[0]));
    check_eq("busy_cnt0", 32'(if0.busy_cnt), 32'(e_cnt[0]));
    check_eq("err_extra0", 32'(if0.err_extra), 32'(e_ext[0]));
    check_eq("err_timeout0", 32'(if0.err_timeout), 32'(e_to[0]));
    check_eq("req_dropped0", 32'(if0.req_dropped), 32'(e_drop[0]));
    check_eq("gnt1", 32'(if1.gnt), 32'(e_gnt[1]));
    check_eq("active1", 32'(if1.active), 32'(e_act[1]));
    check_eq("busy_cnt1", 32'(if1.busy_cnt), 32'(e_cnt[1]));
    check_eq("err_extra1", 32'(if1.err_extra), 32'(e_ext[1]));
    check_eq("err_timeout1", 32'(if1.err_timeout), 32'(e_to[1]));
    check_eq("req_dropped1", 32'(if1.req_dropped), 32'(e_drop[1]));
  endtask

  // driver: one call per clock edge, outputs checked 1 time unit after it
  task automatic cyc(input bit r, input bit b, input bit rs);
    req_d  = r;
    busy_d = b;
    rst    = rs;
    @(posedge clk);
    model_step(0, GAP0, r, b, rs);
    model_step(1, GAP1, r, b, rs);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    check_eq("rst_state0", 32'(if0.state), 32'(IDLE));
    check_eq("rst_state1", 32'(if1.state), 32'(IDLE));

    // req e0, busy e2/e4/e6
    for (int e = 0; e <= 12; e++) begin
      cyc(e == 0, (e == 2) || (e == 4) || (e == 6), 1'b0);
      if (e == 6) begin
        check_eq("t1_gnt0", 32'(if0.gnt), 32'd1);
        check_eq("t1_cnt0", 32'(if0.busy_cnt), 32'd3);
        check_eq("t1_act1", 32'(if1.active), 32'd1);
      end
      if (e == 11) check_eq("t2_gnt1", 32'(if1.gnt), 32'd1);
    end
    idle(3);

    // extra busy during the gap
    for (int e = 0; e <= 12; e++) begin
      cyc(e == 0, (e == 2) || (e == 4) || (e == 6) || (e == 9), 1'b0);
      if (e == 9) check_eq("t3_extra1", 32'(if1.err_extra), 32'd1);
      if (e == 10) check_eq("t3_state1", 32'(if1.state), 32'(IDLE));
    end
    idle(3);

    // only two busy pulses
    for (int e = 0; e <= 25; e++) begin
      cyc(e == 0, (e == 2) || (e == 4), 1'b0);
`ifdef BUSY_GNT_TIMEOUT_EN
      if (e == 20) begin
        check_eq("t4_to0", 32'(if0.err_timeout), 32'd1);
        check_eq("t4_to1", 32'(if1.err_timeout), 32'd1);
      end
`else
      if (e == 25) check_eq("t4_act0", 32'(if0.active), 32'd1);
`endif
    end
    cyc(1'b0, 1'b0, 1'b1);

    // req during COUNT, then req in u0's GRANT cycle
    for (int e = 0; e <= 13; e++) begin
      cyc((e == 0) || (e == 3) || (e == 7), (e == 2) || (e == 4) || (e == 6), 1'b0);
      if (e == 3) check_eq("t5_drop0", 32'(if0.req_dropped), 32'd1);
      if (e == 6) check_eq("t5_gnt0", 32'(if0.gnt), 32'd1);
      if (e == 7) begin
        check_eq("t5_b2b_act0", 32'(if0.active), 32'd1);
        check_eq("t5_b2b_cnt0", 32'(if0.busy_cnt), 32'd0);
        check_eq("t5_drop1", 32'(if1.req_dropped), 32'd1);
      end
      if (e == 11) check_eq("t5_gnt1", 32'(if1.gnt), 32'd1);
    end
    cyc(1'b0, 1'b0, 1'b1);

    // reset mid-COUNT, then a clean request
    for (int e = 0; e <= 10; e++) begin
      cyc((e == 0) || (e == 6), (e == 2) || (e == 4) || (e >= 7 && e <= 9), e == 5);
      if (e == 5) begin
        check_eq("t6_act0", 32'(if0.active), 32'd0);
        check_eq("t6_cnt0", 32'(if0.busy_cnt), 32'd0);
      end
      if (e == 9) check_eq("t6_gnt0", 32'(if0.gnt), 32'd1);
    end
    idle(8);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      cyc($urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 299) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
